// File: rtl/autobaud_ctrl_pkg.sv
// Shared types and constants for the auto-baud calibration controller.
package autobaud_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitHigh,
    StArmed,
    StMeasure,
    StCheck,
    StApply,
    StErr
  } ab_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SHORT    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_MISMATCH = 2'd3;

  // Shift that divides the 8-bit-period total by 8*oversample.
  function automatic int unsigned round_shift(input int unsigned oversample);
    return $clog2(8 * oversample);
  endfunction

endpackage

// File: rtl/autobaud_ctrl_rx_edge_sync.sv
// Two-flop synchroniser for an asynchronous serial line plus a falling-edge pulse.
module rx_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q, rx_s0_q, rx_s1_q;

  // Sync chain resets high (idle line) so reset release cannot fake an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b1;
      rx_s0_q <= 1'b1;
      rx_s1_q <= 1'b1;
    end else begin
      meta_q  <= rx_i;
      rx_s0_q <= meta_q;
      rx_s1_q <= rx_s0_q;
    end
  end

  assign rx_s_o = rx_s0_q;
  assign fall_o = rx_s1_q & ~rx_s0_q;

endmodule

// File: rtl/autobaud_ctrl.sv
// Measures a 0x55 calibration character and loads the rounded baud divisor.
module autobaud_ctrl
  import autobaud_ctrl_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned MIN_BIT    = 16,
  parameter int unsigned DEFAULT_M  = 166
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        start,
  input  logic        abort,
  output logic        set_m,
  output logic [31:0] m,
  output logic        busy,
  output logic        locked,
  output logic [1:0]  err
);

  localparam int unsigned NW    = CNT_W + 2;
  localparam int unsigned RW    = CNT_W + 3;
  localparam int unsigned Shift = round_shift(OVERSAMPLE);
  localparam logic [NW-1:0] MinN     = NW'(8 * MIN_BIT);
  localparam logic [RW-1:0] RoundAdd = RW'(4 * OVERSAMPLE);

  ab_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                idx_q, idx_d;
  logic [NW-1:0]             n_q, n_d;
  logic [3:0][CNT_W-1:0]     d_q, d_d;
  logic [31:0]               m_q, m_d;
  logic [1:0]                err_q, err_d;
  logic                      locked_q, locked_d;

  logic                      rx_s, rx_fall;
  logic [CNT_W-1:0]          interval;
  logic [RW-1:0]             n_round;
  logic [31:0]               m_new;
  logic                      mismatch;

  rx_edge_sync u_rx_edge_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .rx_i   (rx),
    .rx_s_o (rx_s),
    .fall_o (rx_fall)
  );

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Interval consistency check and rounded divisor, both consumed in StCheck.
  always_comb begin
    mismatch = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (abs_diff(d_q[i], d_q[0]) > (d_q[0] >> 3)) mismatch = 1'b1;
    end
    interval = cnt_q + CNT_W'(1);
    n_round  = {1'b0, n_q} + RoundAdd;
    m_new    = 32'(n_round >> Shift) - 32'd1;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    n_d      = n_q;
    d_d      = d_q;
    m_d      = m_q;
    err_d    = err_q;
    locked_d = locked_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d  = StWaitHigh;
          err_d    = ERR_NONE;
          locked_d = 1'b0;
        end
      end
      StWaitHigh: if (rx_s) state_d = StArmed;
      StArmed: begin
        if (rx_fall) begin
          state_d = StMeasure;
          cnt_d   = '0;
          idx_d   = '0;
          n_d     = '0;
        end
      end
      StMeasure: begin
        // Saturation beats a coincident edge.
        if (cnt_q == '1) begin
          state_d = StErr;
          err_d   = ERR_TIMEOUT;
        end else if (rx_fall) begin
          d_d[idx_q] = interval;
          n_d        = n_q + NW'(interval);
          cnt_d      = '0;
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StCheck;
        end else begin
          cnt_d = interval;
        end
      end
      StCheck: begin
        if (n_q < MinN) begin
          state_d = StErr;
          err_d   = ERR_SHORT;
        end else if (mismatch) begin
          state_d = StErr;
          err_d   = ERR_MISMATCH;
        end else begin
          state_d = StApply;
          m_d     = m_new;
        end
      end
      StApply: begin
        state_d  = StIdle;
        locked_d = 1'b1;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      m_d      = m_q;
      err_d    = ERR_NONE;
      locked_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      d_q      <= '0;
      m_q      <= 32'(DEFAULT_M);
      err_q    <= ERR_NONE;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      d_q      <= d_d;
      m_q      <= m_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign set_m  = (state_q == StApply);
  assign busy   = (state_q != StIdle) && (state_q != StErr);
  assign m      = m_q;
  assign err    = err_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_autobaud_ctrl.sv
// Randomised self-checking bench: a wide-counter and a narrow-counter instance
// see the same line and are compared against an arithmetic model.
module tb_autobaud_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;

  logic        set_m, busy, locked;
  logic [31:0] m;
  logic [1:0]  err;
  logic        set_m_t, busy_t, locked_t;
  logic [31:0] m_t;
  logic [1:0]  err_t;

  int errors = 0;
  int checks = 0;
  int exp_m   = 166;
  int exp_m_t = 166;

  int pulses = 0, pulses_t = 0, drops = 0, drops_t = 0;
  int m_at_set = 0, m_at_set_t = 0;
  logic set_prev = 1'b0, set_prev_t = 1'b0;

  always #5 clk = ~clk;

  autobaud_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .start  (start),
    .abort  (abort),
    .set_m  (set_m),
    .m      (m),
    .busy   (busy),
    .locked (locked),
    .err    (err)
  );

  autobaud_ctrl #(.CNT_W(8)) dut_t (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .start  (start),
    .abort  (abort),
    .set_m  (set_m_t),
    .m      (m_t),
    .busy   (busy_t),
    .locked (locked_t),
    .err    (err_t)
  );

  // Load-strobe monitor: pulse count, value seen with the pulse, busy drop after it.
  always @(negedge clk) begin
    if (set_m)   begin pulses   <= pulses + 1;   m_at_set   <= int'(m);   end
    if (set_m_t) begin pulses_t <= pulses_t + 1; m_at_set_t <= int'(m_t); end
    if (set_prev && !busy)     drops   <= drops + 1;
    if (set_prev_t && !busy_t) drops_t <= drops_t + 1;
    set_prev   <= set_m;
    set_prev_t <= set_m_t;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: err code for four measured intervals with a w-bit interval counter.
  function automatic int ref_err(input int d0, input int d1, input int d2, input int d3,
                                 input int w);
    int d[4];
    int n;
    d = '{d0, d1, d2, d3};
    n = 0;
    foreach (d[i]) begin
      if (d[i] >= (1 << w)) return 2;
      n += d[i];
    end
    if (n < 8 * 16) return 1;
    for (int i = 1; i < 4; i++) begin
      int diff;
      diff = d[i] - d0;
      if (diff < 0) diff = -diff;
      if (diff > d0 / 8) return 3;
    end
    return 0;
  endfunction

  function automatic int ref_div(input int n);
    return (n + 64) / 128 - 1;
  endfunction

  task automatic seg(input logic lvl, input int cycles);
    rx = lvl;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // One calibration: falling edges separated by d0..d3, each low phase 'lo' cycles.
  task automatic run_cal(input string tag, input int lo,
                         input int d0, input int d1, input int d2, input int d3);
    int e, et, n, pb, pbt, db, dbt;
    int d[4];
    d   = '{d0, d1, d2, d3};
    n   = d0 + d1 + d2 + d3;
    e   = ref_err(d0, d1, d2, d3, 24);
    et  = ref_err(d0, d1, d2, d3, 8);
    pb  = pulses;  pbt = pulses_t;
    db  = drops;   dbt = drops_t;
    pulse_start();
    check_eq({tag, "_busy"}, busy, 1);
    check_eq({tag, "_busy_t"}, busy_t, 1);
    seg(1'b1, 3);
    foreach (d[i]) begin
      seg(1'b0, lo);
      seg(1'b1, d[i] - lo);
    end
    seg(1'b0, lo);
    rx = 1'b1;
    for (int k = 0; k < 3000 && (busy || busy_t); k++) @(negedge clk);
    check_eq({tag, "_done"}, busy | busy_t, 0);
    repeat (2) @(negedge clk);
    if (e == 0) exp_m = ref_div(n);
    if (et == 0) exp_m_t = ref_div(n);
    check_eq({tag, "_err"}, err, e);
    check_eq({tag, "_locked"}, locked, (e == 0));
    check_eq({tag, "_m"}, m, exp_m);
    check_eq({tag, "_pulses"}, pulses - pb, (e == 0));
    check_eq({tag, "_err_t"}, err_t, et);
    check_eq({tag, "_locked_t"}, locked_t, (et == 0));
    check_eq({tag, "_m_t"}, m_t, exp_m_t);
    check_eq({tag, "_pulses_t"}, pulses_t - pbt, (et == 0));
    if (e == 0) begin
      check_eq({tag, "_m_at_set"}, m_at_set, exp_m);
      check_eq({tag, "_busy_drop"}, drops - db, 1);
    end
    if (et == 0) begin
      check_eq({tag, "_m_at_set_t"}, m_at_set_t, exp_m_t);
      check_eq({tag, "_busy_drop_t"}, drops_t - dbt, 1);
    end
  endtask

  // Start a calibration and stop two edges into the measurement.
  task automatic partial_cal(input int p);
    pulse_start();
    seg(1'b1, 3);
    seg(1'b0, p);
    seg(1'b1, p);
    seg(1'b0, p);
    seg(1'b1, p / 2);
  endtask

  initial begin
    int pb, pbt;
    repeat (3) @(negedge clk);
    check_eq("rst_m", m, 166);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_set_m", set_m, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    run_cal("short", 10, 20, 20, 20, 20);
    run_cal("p160", 160, 320, 320, 320, 320);
    run_cal("p2604", 2604, 5208, 5208, 5208, 5208);
    run_cal("stretch", 160, 320, 320, 400, 320);
    run_cal("p50", 50, 100, 100, 100, 100);

    // Line stuck low: the narrow counter saturates, the wide one is aborted.
    pb = pulses; pbt = pulses_t;
    pulse_start();
    seg(1'b1, 3);
    rx = 1'b0;
    for (int k = 0; k < 600 && busy_t; k++) @(negedge clk);
    check_eq("tmo_err_t", err_t, 2);
    check_eq("tmo_locked_t", locked_t, 0);
    check_eq("tmo_pulses_t", pulses_t - pbt, 0);
    check_eq("tmo_m_t", m_t, exp_m_t);
    check_eq("tmo_busy_wide", busy, 1);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check_eq("tmo_abort_busy", busy, 0);
    check_eq("tmo_abort_err", err, 0);
    check_eq("tmo_err_t_sticky", err_t, 2);
    rx = 1'b1;
    repeat (5) @(negedge clk);

    // Abort mid-measurement.
    pb = pulses; pbt = pulses_t;
    partial_cal(60);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_busy_t", busy_t, 0);
    check_eq("abort_locked", locked, 0);
    check_eq("abort_err", err, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("abort_pulses", pulses - pb + pulses_t - pbt, 0);
    check_eq("abort_m", m, exp_m);

    // Asynchronous reset mid-measurement.
    partial_cal(60);
    #1 reset = 1'b0;
    #1;
    check_eq("areset_busy", busy, 0);
    check_eq("areset_m", m, 166);
    check_eq("areset_m_t", m_t, 166);
    check_eq("areset_set_m", set_m, 0);
    rx = 1'b1;
    exp_m = 166;
    exp_m_t = 166;
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("areset_pulses", pulses - pb + pulses_t - pbt, 0);
    run_cal("post_reset", 160, 320, 320, 320, 320);

    for (int r = 0; r < 8; r++) begin
      int p;
      int j[4];
      p = int'($urandom_range(8, 140));
      foreach (j[i]) j[i] = int'($urandom_range(0, p / 2)) - p / 4;
      run_cal($sformatf("rnd%0d", r), p, 2 * p + j[0], 2 * p + j[1], 2 * p + j[2],
              2 * p + j[3]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
